// File: rtl/tunnel_wall_gen_pkg.sv
// Shared constants, state encoding and LFSR step for the tunnel wall generator.
package tunnel_wall_gen_pkg;

   localparam int unsigned MAP_COLS = 160;
   localparam int unsigned MAP_ROWS = 120;

   localparam logic [1:0] WALL_OPEN  = 2'b00;
   localparam logic [1:0] WALL_SOLID = 2'b01;
   localparam logic [1:0] WALL_EDGE  = 2'b10;

   // Fibonacci taps 16,14,13,11 (bits 15,13,12,10)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      RUN    = 2'd1,
      SCROLL = 2'd2
   } state_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/tunnel_lfsr16.sv
// 16-bit Fibonacci LFSR used to randomise the tunnel left edge on each scroll.
module tunnel_lfsr16
   import tunnel_wall_gen_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        advance,
   output logic [15:0] state
);

   always_ff @(posedge clock) begin
      if (rst)
         state <= SEED;
      else if (advance)
         state <= lfsr_next(state);
   end

endmodule

// File: rtl/tunnel_wall_gen.sv
// Scrolling tunnel wall map: ring buffer of per-row edges, fill/run/scroll FSM,
// registered per-pixel wall code and per-frame icon collision.
module tunnel_wall_gen
   import tunnel_wall_gen_pkg::*;
#(
   parameter int unsigned MIN_EDGE      = 4,
   parameter int unsigned DEFAULT_WIDTH = 64,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        video_on,
   input  logic [9:0]  pixel_row,
   input  logic [9:0]  pixel_column,
   input  logic        scroll_en,
   input  logic [1:0]  speed,
   input  logic [7:0]  tunnel_width,
   input  logic [7:0]  icon_x,
   input  logic [6:0]  icon_y,
   output logic [1:0]  wall,
   output logic        collide,
   output logic        ready,
   output logic [15:0] scroll_count
);

   localparam logic [7:0] FILL_LEFT  = 8'((MAP_COLS - DEFAULT_WIDTH) / 2);
   localparam logic [7:0] FILL_RIGHT = 8'((MAP_COLS - DEFAULT_WIDTH) / 2 + DEFAULT_WIDTH);
   localparam logic [7:0] W_MIN      = 8'd8;
   localparam logic [7:0] W_MAX      = 8'(MAP_COLS - 2 * MIN_EDGE);
   localparam logic [7:0] EDGE_MIN   = 8'(MIN_EDGE);
   localparam logic [7:0] EDGE_SPAN  = 8'(MAP_COLS - MIN_EDGE);
   localparam logic [6:0] ROW_LAST   = 7'(MAP_ROWS - 1);
   localparam logic [7:0] ROWS8      = 8'(MAP_ROWS);

   state_t      state, state_nx;
   logic [6:0]  head, fill_idx, head_nx;
   logic [1:0]  frame_cnt;
   logic [15:0] lfsr;
   logic        frame_tick;

   logic [7:0]  left_mem  [MAP_ROWS];
   logic [7:0]  right_mem [MAP_ROWS];

   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [7:0]  wr_left, wr_right;

   logic [1:0]  step;
   logic [7:0]  w, max_left, cand, new_left, new_right;

   logic        row_ok, icon_ok, icon_hit;
   logic [6:0]  pix_addr, icon_addr;
   logic [7:0]  pix_left, pix_right, icon_left, icon_right, col;
   logic [1:0]  wall_nx;

   function automatic logic [6:0] ring_addr(input logic [6:0] base, input logic [6:0] ofs);
      logic [7:0] sum;
      sum = {1'b0, base} + {1'b0, ofs};
      return (sum >= ROWS8) ? 7'(sum - ROWS8) : sum[6:0];
   endfunction

   tunnel_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clock   (clock),
      .rst     (rst),
      .advance (state == SCROLL),
      .state   (lfsr)
   );

   assign frame_tick = (pixel_row == 10'd479) && (pixel_column == 10'd639);
   assign head_nx    = (head == 7'd0) ? ROW_LAST : head - 7'd1;

   // Low two bits of the advanced LFSR without computing the whole next state
   assign step = {lfsr[0], ^(lfsr & LFSR_TAPS)};

   always_comb begin
      w = tunnel_width;
      if (w < W_MIN)
         w = W_MIN;
      else if (w > W_MAX)
         w = W_MAX;
      max_left = EDGE_SPAN - w;
      cand     = left_mem[head];
      case (step)
         2'b00:   cand = cand - 8'd1;
         2'b11:   cand = cand + 8'd1;
         default: cand = cand;
      endcase
      if (cand < EDGE_MIN)
         cand = EDGE_MIN;
      else if (cand > max_left)
         cand = max_left;
      new_left  = cand;
      new_right = cand + w;
   end

   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      wr_addr  = fill_idx;
      wr_left  = FILL_LEFT;
      wr_right = FILL_RIGHT;
      case (state)
         FILL: begin
            wr_en = 1'b1;
            if (fill_idx == ROW_LAST)
               state_nx = RUN;
         end
         RUN: begin
            if (frame_tick && scroll_en && (frame_cnt == speed))
               state_nx = SCROLL;
         end
         SCROLL: begin
            wr_en    = 1'b1;
            wr_addr  = head_nx;
            wr_left  = new_left;
            wr_right = new_right;
            state_nx = RUN;
         end
         default: state_nx = FILL;
      endcase
      if (rst)
         wr_en = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         left_mem[wr_addr]  <= wr_left;
         right_mem[wr_addr] <= wr_right;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state        <= FILL;
         fill_idx     <= '0;
         head         <= '0;
         frame_cnt    <= '0;
         ready        <= 1'b0;
         collide      <= 1'b0;
         scroll_count <= '0;
      end else begin
         state <= state_nx;
         case (state)
            FILL: begin
               fill_idx <= fill_idx + 7'd1;
               if (fill_idx == ROW_LAST)
                  ready <= 1'b1;
            end
            RUN: begin
               if (frame_tick) begin
                  collide <= icon_hit;
                  if (scroll_en)
                     frame_cnt <= (frame_cnt == speed) ? 2'd0 : frame_cnt + 2'd1;
               end
            end
            SCROLL: begin
               head         <= head_nx;
               scroll_count <= scroll_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

   // Off-screen rows address row 0 so the read index always stays in range
   always_comb begin
      row_ok    = ready && video_on && (pixel_row <= 10'd479);
      pix_addr  = ring_addr(head, row_ok ? pixel_row[8:2] : 7'd0);
      pix_left  = left_mem[pix_addr];
      pix_right = right_mem[pix_addr];
      col       = pixel_column[9:2];
      wall_nx   = WALL_OPEN;
      if (row_ok) begin
         if ((col < pix_left) || (col > pix_right))
            wall_nx = WALL_SOLID;
         else if ((col == pix_left) || (col == pix_right))
            wall_nx = WALL_EDGE;
      end
   end

   always_comb begin
      icon_ok    = (icon_y < 7'(MAP_ROWS));
      icon_addr  = ring_addr(head, icon_ok ? icon_y : 7'd0);
      icon_left  = left_mem[icon_addr];
      icon_right = right_mem[icon_addr];
      icon_hit   = icon_ok && ((icon_x <= icon_left) || (icon_x >= icon_right));
   end

   always_ff @(posedge clock) begin
      if (rst)
         wall <= WALL_OPEN;
      else
         wall <= wall_nx;
   end

endmodule

// File: tb/tb_tunnel_wall_gen.sv
// Directed self-checking bench for tunnel_wall_gen with an independent map/LFSR model.
module tb_tunnel_wall_gen;

   logic        clock = 1'b0;
   logic        rst;
   logic        video_on;
   logic [9:0]  pixel_row, pixel_column;
   logic        scroll_en;
   logic [1:0]  speed;
   logic [7:0]  tunnel_width, icon_x;
   logic [6:0]  icon_y;
   logic [1:0]  wall;
   logic        collide, ready;
   logic [15:0] scroll_count;

   int n_total = 0, n_pass = 0, n_fail = 0;

   int          m_left [120];
   int          m_right[120];
   int          m_head, m_fcnt;
   logic [15:0] m_lfsr;

   tunnel_wall_gen #(
      .MIN_EDGE      (4),
      .DEFAULT_WIDTH (64),
      .LFSR_SEED     (16'hACE1)
   ) dut (
      .clock        (clock),
      .rst          (rst),
      .video_on     (video_on),
      .pixel_row    (pixel_row),
      .pixel_column (pixel_column),
      .scroll_en    (scroll_en),
      .speed        (speed),
      .tunnel_width (tunnel_width),
      .icon_x       (icon_x),
      .icon_y       (icon_y),
      .wall         (wall),
      .collide      (collide),
      .ready        (ready),
      .scroll_count (scroll_count)
   );

   always #20 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 120; i++) begin
         m_left[i]  = 48;
         m_right[i] = 112;
      end
      m_head = 0;
      m_fcnt = 0;
      m_lfsr = 16'hACE1;
   endtask

   task automatic m_scroll();
      int wd, l;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      wd = int'(tunnel_width);
      if (wd < 8) wd = 8;
      if (wd > 152) wd = 152;
      l = m_left[m_head];
      if (m_lfsr[1:0] == 2'b00) l = l - 1;
      else if (m_lfsr[1:0] == 2'b11) l = l + 1;
      if (l < 4) l = 4;
      if (l > 156 - wd) l = 156 - wd;
      m_head = (m_head == 0) ? 119 : m_head - 1;
      m_left[m_head]  = l;
      m_right[m_head] = l + wd;
   endtask

   function automatic logic [1:0] exp_wall(input int m, input int c);
      int idx;
      idx = (m_head + m) % 120;
      if (c < m_left[idx] || c > m_right[idx]) return 2'b01;
      if (c == m_left[idx] || c == m_right[idx]) return 2'b10;
      return 2'b00;
   endfunction

   task automatic frame();
      pixel_row    = 10'd479;
      pixel_column = 10'd639;
      step();
      pixel_row    = 10'd0;
      pixel_column = 10'd0;
      step();
      if (scroll_en) begin
         if (m_fcnt == int'(speed)) begin
            m_fcnt = 0;
            m_scroll();
         end else
            m_fcnt++;
      end
   endtask

   task automatic chk_pix(input string tag, input int row, input int colp,
                          input logic von, input logic [1:0] exp);
      pixel_row    = 10'(row);
      pixel_column = 10'(colp);
      video_on     = von;
      step();
      chk(tag, 32'(wall), 32'(exp));
   endtask

   task automatic chk_map(input string tag);
      int idx, cols[4];
      for (int m = 0; m < 120; m++) begin
         idx     = (m_head + m) % 120;
         cols[0] = m_left[idx] - 1;
         cols[1] = m_left[idx];
         cols[2] = m_left[idx] + 1;
         cols[3] = m_right[idx];
         for (int k = 0; k < 4; k++)
            chk_pix(tag, m * 4, cols[k] * 4, 1'b1, exp_wall(m, cols[k]));
      end
   endtask

   task automatic wait_ready(input string tag);
      int cnt;
      cnt = 0;
      while (ready !== 1'b1 && cnt < 200) begin
         step();
         cnt++;
      end
      chk(tag, 32'(cnt), 32'd120);
   endtask

   initial begin
      rst = 1'b1; video_on = 1'b1; pixel_row = '0; pixel_column = '0;
      scroll_en = 1'b0; speed = 2'd0; tunnel_width = 8'd64;
      icon_x = 8'd0; icon_y = 7'd0;
      m_reset();
      step();
      step();
      chk("rst_wall", 32'(wall), 32'd0);
      chk("rst_collide", 32'(collide), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_count", 32'(scroll_count), 32'd0);

      // 1: fill length and first reads
      rst = 1'b0;
      wait_ready("fill_len");
      chk_pix("rd_edge_l", 0, 192, 1'b1, 2'b10);
      chk_pix("rd_solid", 0, 100, 1'b1, 2'b01);
      chk_pix("rd_open", 0, 320, 1'b1, 2'b00);
      chk_pix("rd_edge_r", 0, 448, 1'b1, 2'b10);
      chk_pix("rd_solid_r", 477, 452, 1'b1, 2'b01);
      chk_pix("rd_blank", 0, 100, 1'b0, 2'b00);
      chk_pix("rd_row480", 480, 100, 1'b1, 2'b00);

      // 4: collision against the filled map, no scrolling
      icon_y = 7'd0; icon_x = 8'd48; frame();
      chk("col_left", 32'(collide), 32'd1);
      icon_x = 8'd49; frame();
      chk("col_inside", 32'(collide), 32'd0);
      icon_x = 8'd48; step();
      chk("col_held", 32'(collide), 32'd0);
      icon_x = 8'd112; frame();
      chk("col_right", 32'(collide), 32'd1);
      icon_x = 8'd111; frame();
      chk("col_inside_r", 32'(collide), 32'd0);
      icon_x = 8'd112; frame();
      icon_y = 7'd120; icon_x = 8'd0; frame();
      chk("col_y_oob", 32'(collide), 32'd0);
      chk("noscroll_cnt", 32'(scroll_count), 32'd0);
      icon_y = 7'd0; icon_x = 8'd60;

      // 2: scroll cadence speed=2
      scroll_en = 1'b1; speed = 2'd2;
      frame(); frame();
      chk("cad_2f", 32'(scroll_count), 32'd0);
      frame();
      chk("cad_3f", 32'(scroll_count), 32'd1);
      for (int i = 0; i < 6; i++) frame();
      chk("cad_9f", 32'(scroll_count), 32'd3);
      chk("cad_head", 32'(m_head), 32'd117);
      chk_map("cad_map");

      // 3: oversized width clamps to 152 with left pinned at 4
      speed = 2'd0; tunnel_width = 8'd200;
      frame(); frame(); frame();
      chk("wide_cnt", 32'(scroll_count), 32'd6);
      for (int m = 0; m < 3; m++) begin
         chk_pix("wide_l_edge", m * 4, 16, 1'b1, 2'b10);
         chk_pix("wide_l_solid", m * 4, 12, 1'b1, 2'b01);
         chk_pix("wide_open", m * 4, 20, 1'b1, 2'b00);
         chk_pix("wide_r_edge", m * 4, 624, 1'b1, 2'b10);
         chk_pix("wide_r_solid", m * 4, 628, 1'b1, 2'b01);
      end

      // 5: long random walk around the ring
      tunnel_width = 8'd40;
      for (int i = 0; i < 200; i++) frame();
      tunnel_width = 8'd3;
      for (int i = 0; i < 20; i++) frame();
      tunnel_width = 8'd96;
      for (int i = 0; i < 74; i++) frame();
      chk("walk_cnt", 32'(scroll_count), 32'd300);
      chk_map("walk_map");

      // 6: reset landing in the SCROLL cycle
      pixel_row = 10'd479; pixel_column = 10'd639;
      step();
      rst = 1'b1; pixel_row = 10'd0; pixel_column = 10'd0;
      step();
      rst = 1'b0;
      m_reset();
      chk("mid_count", 32'(scroll_count), 32'd0);
      chk("mid_ready", 32'(ready), 32'd0);
      chk("mid_wall", 32'(wall), 32'd0);
      wait_ready("refill_len");
      chk_map("refill_map");
      tunnel_width = 8'd64;
      frame();
      chk("post_cnt", 32'(scroll_count), 32'd1);
      chk_map("post_map");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tunnel_wall_gen.md
Name: tunnel_wall_gen

Overview:
- Generates the scrolling tunnel wall map for the VGA game path.
- Sits between the display timing generator and the colorizer. It consumes pixel_row/pixel_column/video_on and produces the 2-bit wall code for the colorizer's wall input.
- Holds a 160x120 coarse map (screen pixels >>2) as a ring buffer of per-row left/right edges.
- Each scroll adds one new LFSR-randomised row at the top. It also reports icon/wall collision once per frame.

Parameters:
- MAP_COLS, 160, coarse map columns (640>>2)
- MAP_ROWS, 120, coarse map rows (480>>2)
- MIN_EDGE, 4, minimum left-edge column and minimum right margin
- DEFAULT_WIDTH, 64, tunnel width written during reset fill
- LFSR_SEED, 16'hACE1, LFSR value after reset (must be nonzero)

Ports:
- clock  in  1  25 MHz pixel clock
- rst  in  1  synchronous, active-high reset
- video_on  in  1  visible-region flag from the timing generator
- pixel_row  in  10  current pixel row (0..479 visible)
- pixel_column  in  10  current pixel column (0..639 visible)
- scroll_en  in  1  1 = tunnel advances
- speed  in  2  frames per scroll, minus 1
- tunnel_width  in  8  requested width in map columns
- icon_x  in  8  icon map column
- icon_y  in  7  icon map row
- wall  out  2  00 open, 01 wall, 10 edge, 11 unused (never driven)
- collide  out  1  icon column at/outside the edges of row icon_y, sampled per frame
- ready  out  1  map initialised
- scroll_count  out  16  scrolls since reset, wraps at 16'hFFFF -> 0

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high. When asserted, rst has priority over everything.
- Reset values: wall=00, collide=0, ready=0, scroll_count=0, lfsr=LFSR_SEED, head=0, frame_cnt=0, state=FILL, fill_idx=0.
- FILL state: writes entry fill_idx with left=(MAP_COLS-DEFAULT_WIDTH)/2=48, right=left+DEFAULT_WIDTH=112, one entry per clock.
  - At fill_idx=MAP_ROWS-1 the write completes and the FSM goes to RUN, with ready=1 from the next cycle.
  - FILL lasts exactly 120 clocks after rst deasserts.
  - Frame ticks during FILL are ignored.
  - wall=00 whenever ready=0.
- frame_tick: one-cycle pulse when pixel_row==479 && pixel_column==639.
- RUN state, on frame_tick:
  - collide is updated from the pre-scroll map.
  - If scroll_en=1: when frame_cnt==speed, frame_cnt clears and the FSM goes to SCROLL; otherwise frame_cnt increments.
  - If scroll_en=0: frame_cnt holds and no scroll occurs.
- SCROLL state (1 clock), then back to RUN:
  - head <= (head==0) ? MAP_ROWS-1 : head-1.
  - lfsr advances one step: Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0.
  - step = new lfsr[1:0]: 00 -> left-1, 11 -> left+1, otherwise hold.
  - Width w = tunnel_width clamped to [8, MAP_COLS-2*MIN_EDGE=152].
  - New left is clamped to [MIN_EDGE, MAP_COLS-MIN_EDGE-w]; right = left+w.
  - The entry is written at the new head.
  - scroll_count increments.
- Map addressing: map row m = pixel_row>>2 reads entry (head+m) mod MAP_ROWS. The sum is at most 238, so one conditional subtract of 120 suffices.
- Wall code: c = pixel_column>>2 is compared against that entry.
  - c<left or c>right -> 01
  - c==left or c==right -> 10
  - else 00
  - Result is forced to 00 if video_on=0 or pixel_row>479.
- Latency: wall is registered, exactly 1 clock after the pixel inputs. The map read is combinational (distributed RAM).
- collide uses entry (head+icon_y) mod MAP_ROWS: 1 if icon_x<=left or icon_x>=right.
  - icon_y>=MAP_ROWS reads as collide=0.
  - Held between frame ticks.
- Simultaneous events:
  - A frame tick coinciding with SCROLL cannot occur, since SCROLL lasts 1 clock and ticks are ≥1 frame apart.
  - A write during display is permitted. Pixel reads in SCROLL use the old head for that cycle.
- Reset mid-operation: rst asserted during FILL, RUN or SCROLL returns to FILL with all reset values. Any in-flight scroll write is discarded.

Decomposition:
- Shared package holds:
  - wall code constants WALL_OPEN=2'b00, WALL_SOLID=2'b01, WALL_EDGE=2'b10
  - MAP_COLS/MAP_ROWS
  - state encoding FILL/RUN/SCROLL
  - LFSR tap mask
- One natural sub-module, tunnel_lfsr16: advance strobe, seed on rst, 16-bit state out.
- Ring buffer and FSM stay in tunnel_wall_gen.

Test Plan:
1. Fill and first read: rst 1 clock then release. Expect ready=0 for 120 clocks, then 1. Then row 0, col 192 (c=48) -> wall=10 one clock later; col 100 (c=25) -> 01; col 320 (c=80) -> 00; video_on=0 -> 00.
2. Scroll cadence: scroll_en=1, speed=2, drive 9 frames. Expect scroll_count=3, head sequence 0->119->118->117 (wrap checked).
3. LFSR walk: force lfsr state giving step 00 with left at MIN_EDGE=4. Expect new left=4 (clamped). With tunnel_width=200, expect width 152 and left=4.
4. Collision: icon_y=0, icon_x=48 -> collide=1 after next frame_tick; icon_x=49 -> 0; icon_x=112 -> 1; icon_y=120 -> 0.
5. Ring wrap over many scrolls: run 300 scrolls with a golden model. Compare every pixel wall code for one frame, and check scroll_count=300.
6. Reset mid-SCROLL: assert rst in the SCROLL cycle. Expect scroll_count=0, head=0, ready=0, and all entries restored to 48/112 after FILL.
